avmm_ccip_host_rd_mux: RTL

- Parametrised N-channel front end for the AVMM-to-CCI-P host read bridge.
- Merges NUM_CHANNELS AVMM burst-read masters onto one AVMM read port feeding avmm_ccip_host_rd.
- Uses round-robin arbitration per command and an in-order tag FIFO to route read data back to the issuing channel.
- Lets several DMA engines share one c0 host read path; the current single-master connection cannot do this.

---
 rtl/avmm_ccip_host_rd_mux_pkg.sv | 13 +
 rtl/avmm_ccip_host_rd_mux_if.sv | 30 +++
 rtl/avmm_ccip_host_rd_mux_tag_fifo.sv | 51 +++++
 rtl/avmm_ccip_host_rd_mux.sv | 122 ++++++++++++
 4 files changed

// File: rtl/avmm_ccip_host_rd_mux_pkg.sv
// Shared types for the AVMM read mux: the routing tag kept per outstanding
// burst and the channel-count ceiling that sizes the tag's channel field.
package avmm_ccip_host_rd_mux_pkg;
  localparam int CCIP_AVMM_RD_MUX_MAX_CHANNELS = 16;
  localparam int RD_MUX_CHAN_W = $clog2(CCIP_AVMM_RD_MUX_MAX_CHANNELS);
  // Wide enough for any BURST_WIDTH up to 8.
  localparam int RD_MUX_BC_W   = 8;

  typedef struct packed {
    logic [RD_MUX_CHAN_W-1:0] chan;
    logic [RD_MUX_BC_W-1:0]   burstcount;
  } t_rd_mux_tag;
endpackage

// File: rtl/avmm_ccip_host_rd_mux_if.sv
// Bus bundle for the read mux: N upstream AVMM burst-read masters (m_*) and
// the single downstream AVMM read port (s_*). slave = mux view, master = env view.
interface avmm_ccip_host_rd_mux_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 48,
  parameter int BURST_WIDTH  = 3
);
  logic [NUM_CHANNELS-1:0]                  m_read;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  m_address;
  logic [NUM_CHANNELS-1:0][BURST_WIDTH-1:0] m_burstcount;
  logic [NUM_CHANNELS-1:0]                  m_waitrequest;
  logic [DATA_WIDTH-1:0]                    m_readdata;
  logic [NUM_CHANNELS-1:0]                  m_readdatavalid;
  logic                                     s_read;
  logic [ADDR_WIDTH-1:0]                    s_address;
  logic [BURST_WIDTH-1:0]                   s_burstcount;
  logic                                     s_waitrequest;
  logic [DATA_WIDTH-1:0]                    s_readdata;
  logic                                     s_readdatavalid;

  modport slave (
    input  m_read, m_address, m_burstcount, s_waitrequest, s_readdata, s_readdatavalid,
    output m_waitrequest, m_readdata, m_readdatavalid, s_read, s_address, s_burstcount
  );
  modport master (
    output m_read, m_address, m_burstcount, s_waitrequest, s_readdata, s_readdatavalid,
    input  m_waitrequest, m_readdata, m_readdatavalid, s_read, s_address, s_burstcount
  );
endinterface

// File: rtl/avmm_ccip_host_rd_mux_tag_fifo.sv
// avmm_rd_tag_fifo: show-ahead FIFO of routing tags, one entry per burst in
// flight. A push while full is taken only when a pop happens the same cycle.
module avmm_rd_tag_fifo
  import avmm_ccip_host_rd_mux_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  t_rd_mux_tag              din,
  input  logic                     pop,
  output t_rd_mux_tag              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  t_rd_mux_tag     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Tag storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/avmm_ccip_host_rd_mux.sv
// avmm_ccip_host_rd_mux: round-robin merge of NUM_CHANNELS AVMM burst-read
// masters onto one read port; an in-order tag FIFO steers returning beats
// back to the issuing channel.
// Optional: define AVMM_RD_MUX_PERF_EN for per-channel beat/stall counters.
module avmm_ccip_host_rd_mux
  import avmm_ccip_host_rd_mux_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 48,
  parameter int BURST_WIDTH     = 3,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  avmm_ccip_host_rd_mux_if.slave             bus,
  output logic                               err_sticky,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
`ifdef AVMM_RD_MUX_PERF_EN
  ,
  output logic [NUM_CHANNELS-1:0][31:0]      perf_beats,
  output logic [NUM_CHANNELS-1:0][31:0]      perf_stall
`endif
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [CW-1:0]          rr_ptr, grant;
  logic                   found, accept, fifo_full, fifo_empty, beat_vld, pop;
  logic [RD_MUX_BC_W-1:0] beat;
  logic [ADDR_WIDTH-1:0]  addr_mux;
  logic [BURST_WIDTH-1:0] bc_mux;
  logic [DATA_WIDTH-1:0]  rd_data;
  t_rd_mux_tag            tag_in, head;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!found && bus.m_read[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
        grant = CW'((int'(rr_ptr) + k) % NUM_CHANNELS);
        found = 1'b1;
      end
    end
  end

  assign addr_mux         = bus.m_address[grant];
  assign bc_mux           = bus.m_burstcount[grant];
  assign bus.s_read       = found && !fifo_full;
  assign bus.s_address    = addr_mux;
  assign bus.s_burstcount = bc_mux;
  assign accept           = bus.s_read && !bus.s_waitrequest;

  // Only the granted channel sees its command taken; everyone else stalls.
  always_comb begin
    bus.m_waitrequest = '1;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (grant == CW'(i) && accept) bus.m_waitrequest[i] = 1'b0;
  end

  // A zero burstcount is tracked as one beat so the head always retires.
  assign tag_in.chan       = RD_MUX_CHAN_W'(grant);
  assign tag_in.burstcount = (bc_mux == '0) ? RD_MUX_BC_W'(1) : RD_MUX_BC_W'(bc_mux);

  avmm_rd_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (tag_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // Response routing: data broadcast, valid only to the head tag's channel.
  assign rd_data        = bus.s_readdata;
  assign bus.m_readdata = rd_data;
  assign beat_vld       = bus.s_readdatavalid && !fifo_empty;
  assign pop            = beat_vld && (beat == head.burstcount - 1'b1);

  always_comb begin
    bus.m_readdatavalid = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (head.chan == RD_MUX_CHAN_W'(i)) bus.m_readdatavalid[i] = beat_vld;
  end

  // Arbitration pointer advances past the winner only on an accept.
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= '0;
    else if (accept) rr_ptr <= (grant == CW'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;
  end

  // Beat position within the head burst.
  always_ff @(posedge clk) begin
    if (reset)         beat <= '0;
    else if (beat_vld) beat <= pop ? '0 : beat + 1'b1;
  end

  // Sticky protocol error: orphan beat or zero-length command.
  always_ff @(posedge clk) begin
    if (reset) err_sticky <= 1'b0;
    else if ((bus.s_readdatavalid && fifo_empty) || (accept && bc_mux == '0))
      err_sticky <= 1'b1;
  end

`ifdef AVMM_RD_MUX_PERF_EN
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_perf
    // Per-channel delivered beats and stalled request cycles, free-running.
    always_ff @(posedge clk) begin
      if (reset) begin
        perf_beats[i] <= '0;
        perf_stall[i] <= '0;
      end else begin
        if (bus.m_readdatavalid[i])                   perf_beats[i] <= perf_beats[i] + 1'b1;
        if (bus.m_read[i] && bus.m_waitrequest[i])    perf_stall[i] <= perf_stall[i] + 1'b1;
      end
    end
  end
`endif
endmodule
